// File: rtl/conv_pkg.sv
// Shared types and fixed kernel tables for the streaming 3x3 convolution engine.
package conv_pkg;

    localparam int unsigned KERNEL_NUM = 4;
    localparam int unsigned COEF_BITS  = 5;

    typedef enum logic [1:0] {
        K_IDENTITY = 2'd0,
        K_SHARPEN  = 2'd1,
        K_EDGE     = 2'd2,
        K_GAUSS    = 2'd3
    } kernel_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    // Row index 0 is the oldest line (y-2), column index 0 the oldest pixel (x-2).
    localparam int COEF_TAB [KERNEL_NUM][3][3] = '{
        '{'{ 0,  0,  0}, '{ 0,  1,  0}, '{ 0,  0,  0}},
        '{'{ 0, -1,  0}, '{-1,  5, -1}, '{ 0, -1,  0}},
        '{'{-1, -1, -1}, '{-1,  8, -1}, '{-1, -1, -1}},
        '{'{ 1,  2,  1}, '{ 2,  4,  2}, '{ 1,  2,  1}}
    };

    localparam int SHIFT_TAB [KERNEL_NUM] = '{0, 0, 0, 4};

    function automatic int coef_at(input int k, input int i, input int j);
        return COEF_TAB[k][i][j];
    endfunction

    function automatic int shift_at(input int k);
        return SHIFT_TAB[k];
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One-line delay: tap returns the pixel written DEPTH accepted writes ago.
module conv_line_buffer #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned DEPTH = 640
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [PIX_W-1:0] wr_pix,
    output logic [PIX_W-1:0] tap_pix
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    // Read-before-write at the same slot gives exactly DEPTH writes of delay.
    assign tap_pix = mem[ptr];

    always_ff @(posedge CLK) begin
        if (reset || clr) begin
            ptr <= '0;
        end else if (we) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[ptr] <= wr_pix;
        end
    end

endmodule

// File: rtl/stream_conv3x3.sv
// Streaming 3x3 convolution over one raster frame with selectable fixed kernels.
// Optional CONV_SAT_COUNT_EN adds a per-frame count of clamped results.
module stream_conv3x3
    import conv_pkg::*;
#(
    parameter int unsigned PIX_W     = 8,
    parameter int unsigned IMG_W     = 640,
    parameter int unsigned IMG_H     = 480,
    parameter int unsigned N_KERNELS = KERNEL_NUM,
    parameter int unsigned COEF_W    = COEF_BITS,
    parameter int unsigned ACC_W     = 16
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(N_KERNELS)-1:0] kernel_sel,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PIX_W-1:0]             in_pix,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIX_W-1:0]             out_pix,
    output logic                         busy,
    output logic                         done
`ifdef CONV_SAT_COUNT_EN
    ,
    output logic [19:0]                  sat_count
`endif
);

    localparam int unsigned XW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned YW      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned KW      = $clog2(N_KERNELS);
    localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

    state_e state, state_nx;

    logic [XW-1:0]    x_q;
    logic [YW-1:0]    y_q;
    logic [KW-1:0]    kern_q;
    logic [PIX_W-1:0] lb0_tap, lb1_tap;
    logic [PIX_W-1:0] win [3][2];
    logic [PIX_W-1:0] col [3];

    logic start_ok, accept, is_last, load;
    logic             sat_c;
    logic [PIX_W-1:0] res_c;

    assign start_ok = (state == S_IDLE) && start;
    assign in_ready = (state == S_RUN) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_last  = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));
    assign load     = accept && (x_q >= XW'(2)) && (y_q >= YW'(2));

    conv_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb0 (
        .CLK(CLK), .reset(reset), .clr(start_ok), .we(accept),
        .wr_pix(in_pix), .tap_pix(lb0_tap)
    );

    conv_line_buffer #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_lb1 (
        .CLK(CLK), .reset(reset), .clr(start_ok), .we(accept),
        .wr_pix(lb0_tap), .tap_pix(lb1_tap)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nx = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (accept && is_last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (!out_valid || out_ready) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Raster position of the pixel currently offered on the input stream.
    always_ff @(posedge CLK) begin
        if (reset) begin
            x_q    <= '0;
            y_q    <= '0;
            kern_q <= '0;
        end else if (start_ok) begin
            x_q    <= '0;
            y_q    <= '0;
            kern_q <= kernel_sel;
        end else if (accept) begin
            if (x_q == XW'(IMG_W - 1)) begin
                x_q <= '0;
                y_q <= (y_q == YW'(IMG_H - 1)) ? '0 : y_q + YW'(1);
            end else begin
                x_q <= x_q + XW'(1);
            end
        end
    end

    assign col[0] = lb1_tap;
    assign col[1] = lb0_tap;
    assign col[2] = in_pix;

    // Window keeps the two previous columns; the live column comes straight from the taps.
    always_ff @(posedge CLK) begin
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= col[i];
            end
        end
    end

    always_comb begin
        logic signed [ACC_W-1:0]  sum;
        logic signed [ACC_W-1:0]  shifted;
        logic signed [ACC_W-1:0]  c_ext;
        logic signed [ACC_W-1:0]  p_ext;
        logic signed [COEF_W-1:0] c_coef;
        logic [PIX_W-1:0]         pix_sel;
        sum     = '0;
        shifted = '0;
        c_ext   = '0;
        p_ext   = '0;
        c_coef  = '0;
        pix_sel = '0;
        res_c   = '0;
        sat_c   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                pix_sel = (j == 2) ? col[i] : win[i][j];
                c_coef  = COEF_W'(coef_at(int'(kern_q), i, j));
                c_ext   = ACC_W'(c_coef);
                p_ext   = ACC_W'(pix_sel);
                sum     = sum + c_ext * p_ext;
            end
        end
        shifted = sum >>> shift_at(int'(kern_q));
        if (shifted[ACC_W-1]) begin
            sat_c = 1'b1;
        end else if (shifted > $signed(ACC_W'(PIX_MAX))) begin
            res_c = PIX_W'(PIX_MAX);
            sat_c = 1'b1;
        end else begin
            res_c = PIX_W'(shifted);
        end
    end

    // A new result may replace an accepted one on the same edge without a bubble.
    always_ff @(posedge CLK) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_pix   <= res_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CONV_SAT_COUNT_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            sat_count <= '0;
        end else if (start_ok) begin
            sat_count <= '0;
        end else if (load && sat_c) begin
            sat_count <= sat_count + 20'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_conv3x3.sv
// Directed bench for stream_conv3x3 on a 4x4 frame; covers CONV_SAT_COUNT_EN when defined.
module tb_stream_conv3x3;
    import conv_pkg::*;

    typedef logic [7:0] frame_t [16];
    typedef logic [7:0] res_t   [4];

    logic       CLK = 1'b0;
    logic       reset, start, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [1:0] kernel_sel;
    logic [7:0] in_pix, out_pix;
`ifdef CONV_SAT_COUNT_EN
    logic [19:0] sat_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    stream_conv3x3 #(
        .PIX_W(8), .IMG_W(4), .IMG_H(4), .N_KERNELS(4), .COEF_W(5), .ACC_W(16)
    ) dut (
        .CLK(CLK), .reset(reset), .start(start), .kernel_sel(kernel_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix),
        .busy(busy), .done(done)
`ifdef CONV_SAT_COUNT_EN
        , .sat_count(sat_count)
`endif
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic frame_t ramp_frame();
        frame_t f;
        for (int i = 0; i < 16; i++) f[i] = 8'(10 * (i / 4) + (i % 4));
        return f;
    endfunction

    function automatic frame_t const_frame(input logic [7:0] v);
        frame_t f;
        for (int i = 0; i < 16; i++) f[i] = v;
        return f;
    endfunction

    task automatic begin_frame(input logic [1:0] k);
        start      = 1'b1;
        kernel_sel = k;
        tick();
        start      = 1'b0;
    endtask

    // Streams one frame, compares every accepted result, checks done/busy at the end.
    task automatic run_frame(input string name, input frame_t pix, input res_t exp_res,
                             input int stall_len, input bit mid_start);
        int idx, nres, ndone, stall_left, cyc, tail;
        bit stall_pending, start_sent;
        idx = 0; nres = 0; ndone = 0; stall_left = 0; cyc = 0; tail = 0;
        stall_pending = (stall_len > 0);
        start_sent = 1'b0;
        while (cyc < 300 && tail < 3) begin
            in_valid = (idx < 16);
            in_pix   = (idx < 16) ? pix[idx] : 8'd0;
            if (stall_pending && out_valid) begin
                stall_left    = stall_len;
                stall_pending = 1'b0;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            start = 1'b0;
            if (mid_start && !start_sent && idx == 5) begin
                start      = 1'b1;
                kernel_sel = K_EDGE;
                start_sent = 1'b1;
            end
            @(negedge CLK);
            if (!out_ready) begin
                checks++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_pix !== exp_res[nres]) begin
                    errors++;
                    $display("FAIL %s stall hold: out_valid=%0b in_ready=%0b out_pix=%0d, required 1 0 %0d",
                             name, out_valid, in_ready, out_pix, exp_res[nres]);
                end
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                checks++;
                if (nres >= 4) begin
                    errors++;
                    $display("FAIL %s extra result: got %0d, required none", name, out_pix);
                end else if (out_pix !== exp_res[nres]) begin
                    errors++;
                    $display("FAIL %s result[%0d]: got %0d, required %0d", name, nres, out_pix, exp_res[nres]);
                end
                nres++;
            end
            if (done) ndone++;
            if (ndone > 0) tail++;
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (nres != 4) begin
            errors++;
            $display("FAIL %s result count: got %0d, required 4", name, nres);
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d, required 1 (cycles used %0d)", name, ndone, cyc);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after frame: got %0b, required 0", name, busy);
        end
    endtask

    task automatic check_sat(input string name, input int expected);
`ifdef CONV_SAT_COUNT_EN
        checks++;
        if (sat_count !== 20'(expected)) begin
            errors++;
            $display("FAIL %s sat_count: got %0d, required %0d", name, sat_count, expected);
        end
`else
        if (name.len() < 0 || expected < 0) $display("%s", name);
`endif
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_pix !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: in_ready=%0b out_valid=%0b out_pix=%0d busy=%0b done=%0b, required all 0",
                     name, in_ready, out_valid, out_pix, busy, done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; kernel_sel = 2'd0;
        in_valid = 1'b0; in_pix = 8'd0; out_ready = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        check_sat("reset", 0);
        reset = 1'b0;
        tick();
    endtask

    task automatic test_identity();
        res_t e = '{8'd11, 8'd12, 8'd21, 8'd22};
        begin_frame(K_IDENTITY);
        run_frame("identity", ramp_frame(), e, 0, 1'b0);
        check_sat("identity", 0);
    endtask

    task automatic test_edge_sharpen();
        res_t ez = '{8'd0, 8'd0, 8'd0, 8'd0};
        res_t eh = '{8'd100, 8'd100, 8'd100, 8'd100};
        begin_frame(K_EDGE);
        run_frame("edge_const", const_frame(8'd100), ez, 0, 1'b0);
        check_sat("edge_const", 0);
        begin_frame(K_SHARPEN);
        run_frame("sharpen_const", const_frame(8'd100), eh, 0, 1'b0);
    endtask

    task automatic test_impulse();
        frame_t f = const_frame(8'd0);
        res_t   e = '{8'd255, 8'd0, 8'd0, 8'd0};
        f[5] = 8'd50;
        begin_frame(K_EDGE);
        run_frame("edge_impulse", f, e, 0, 1'b0);
        check_sat("edge_impulse", 4);
    endtask

    task automatic test_back_pressure();
        res_t e = '{8'd64, 8'd64, 8'd64, 8'd64};
        begin_frame(K_GAUSS);
        run_frame("gauss_stall", const_frame(8'd64), e, 5, 1'b0);
    endtask

    task automatic test_mid_reset();
        frame_t f = ramp_frame();
        res_t   e = '{8'd11, 8'd12, 8'd21, 8'd22};
        int cnt = 0;
        int cyc = 0;
        begin_frame(K_IDENTITY);
        while (cnt < 7 && cyc < 50) begin
            in_valid = 1'b1;
            in_pix   = f[cnt];
            @(negedge CLK);
            if (in_ready) cnt++;
            tick();
            cyc++;
        end
        checks++;
        if (cnt != 7) begin
            errors++;
            $display("FAIL mid_reset accepted inputs: got %0d, required 7", cnt);
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check_idle_outputs("mid_reset");
        reset = 1'b0;
        tick();
        begin_frame(K_IDENTITY);
        run_frame("after_reset", f, e, 0, 1'b0);
    endtask

    task automatic test_mid_start();
        res_t e = '{8'd11, 8'd12, 8'd21, 8'd22};
        begin_frame(K_IDENTITY);
        run_frame("mid_start", ramp_frame(), e, 0, 1'b1);
        kernel_sel = K_IDENTITY;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_edge_sharpen();
        test_impulse();
        test_back_pressure();
        test_mid_reset();
        test_mid_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_conv3x3.md
Name: stream_conv3x3

Overview:
- Parametrised streaming 3x3 convolution engine; next generation of the filter datapath.
- Accepts one raster-order frame of grayscale pixels over a valid/ready stream and applies one of N_KERNELS fixed kernels, selected at frame start.
- Emits the (IMG_W-2)x(IMG_H-2) interior result pixels over a second valid/ready stream.
- Sits between the image vector memory read port and the writeback/VGA path.

Parameters:
- PIX_W, 8, pixel width (unsigned)
- IMG_W, 640, pixels per line (>=3)
- IMG_H, 480, lines per frame (>=3)
- N_KERNELS, 4, number of selectable kernels (table in package)
- COEF_W, 5, signed coefficient width
- ACC_W, 16, signed accumulator width; must hold 9*(2^PIX_W-1)*max|coef|

Ports:
- CLK  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a frame; honoured only in IDLE
- kernel_sel  in  $clog2(N_KERNELS)  kernel index; latched on accepted start
- in_valid  in  1  input pixel valid
- in_ready  out  1  engine accepts input pixel
- in_pix  in  PIX_W  input pixel, raster order
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_pix  out  PIX_W  result pixel, saturated
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after last result accepted

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_pix=0, busy=0, done=0, state=IDLE, x/y counters=0, latched kernel=0. Line-buffer contents are not cleared; validity is tracked by the counters.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE->RUN on start. kernel_sel latched and counters cleared on the same edge.
  - RUN->DRAIN on the edge the pixel (IMG_W-1, IMG_H-1) is accepted.
  - DRAIN->DONE when out_valid is 0 or the final result is accepted.
  - DONE->IDLE unconditionally after 1 cycle. done=1 only in DONE.
- start outside IDLE is ignored. kernel_sel changes mid-frame have no effect.
- Input handshake: in_ready = (state==RUN) && (!out_valid || out_ready). Transfer occurs on in_valid && in_ready.
- Each accepted pixel is written to two cascaded IMG_W-deep line buffers and to a 3x3 window register. x wraps at IMG_W-1 and increments y.
- When an accepted pixel has x>=2 and y>=2, the window centred at (x-1, y-1) is computed:
  - sum = sum over i,j of coef[k][i][j] * pixel, in signed ACC_W.
  - result = sum >>> shift[k] (arithmetic shift).
  - result is clamped to [0, 2^PIX_W-1].
- Results are registered into out_pix/out_valid on the next edge, giving a latency of 1 cycle from the accepting edge.
- out_pix and out_valid hold while out_valid && !out_ready. out_valid clears on acceptance unless a new result loads on the same edge.
- Pixels with x<2 or y<2 produce no output. A frame yields exactly (IMG_W-2)*(IMG_H-2) results.
- Simultaneous acceptance of an output and a load of a new result replaces the register contents with no bubble.
- reset mid-frame forces all reset values on the next edge. Any partial output is discarded.

Optional Feature:
- Macro: CONV_SAT_COUNT_EN.
- Defined: adds output sat_count [19:0]. It increments for each result that was clamped (high or low), clears on accepted start, and holds after DONE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package conv_pkg holds:
  - kernel_e enum: K_IDENTITY=0, K_SHARPEN=1, K_EDGE=2, K_GAUSS=3.
  - coefficient table [N_KERNELS][3][3]:
    - identity: center 1.
    - sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0.
    - edge: -1 everywhere, center 8.
    - gauss: 1 2 1 / 2 4 2 / 1 2 1.
  - shift table: 0, 0, 0, 4.
- Sub-module: conv_line_buffer. One IMG_W x PIX_W delay line with write enable; instantiated twice.

Test Plan (IMG_W=4, IMG_H=4, pixel(x,y)=10*y+x unless stated):
1. Identity, in_valid always high, out_ready high -> results 11, 12, 21, 22 in order; done pulses once; busy low after.
2. Edge on constant 100 frame -> four results of 0. Sharpen on constant 100 -> four results of 100.
3. Edge on an all-0 frame except (1,1)=50 -> results 255, 0, 0, 0. sat_count=4 with CONV_SAT_COUNT_EN, since the three -50 results clamp low.
4. Gauss on constant 64, out_ready low for 5 cycles after the first result -> out_pix stable at 64, in_ready=0, four results of 64, no loss or duplication.
5. reset asserted after 7 accepted inputs -> next cycle out_valid=0, busy=0, in_ready=0. A new start with identity yields 11, 12, 21, 22.
6. start and kernel_sel=K_EDGE pulsed mid-frame under identity -> ignored; results remain 11, 12, 21, 22 with a single done.
